// File: rtl/event_index_encoder.sv
// Converts multi-hot event pulses into a stream of indices, one per event,
// behind a valid/ready output slot, with fixed-priority or round-robin arbitration.
module event_index_encoder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDX_W = 3,
   parameter bit          RR    = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] evt_in,
   input  logic             clr,
   output logic [IDX_W-1:0] idx_out,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic [WIDTH-1:0] pending,
   output logic             ovf
);

   logic [WIDTH-1:0] r_pending;
   logic [IDX_W-1:0] r_idx;
   logic             r_valid;
   logic             r_ovf;
   logic [IDX_W-1:0] r_ptr;

   logic             w_slot_free;
   logic [IDX_W-1:0] w_start;
   logic [IDX_W-1:0] w_cand;
   logic [IDX_W-1:0] w_sel;
   logic             w_found;
   logic             w_load;
   logic [WIDTH-1:0] w_load_mask;
   logic [WIDTH-1:0] w_pending_next;
   logic             w_drop;

   assign w_slot_free = !r_valid || idx_ready;
   assign w_start     = RR ? r_ptr : '0;

   // Scan pending from the start point, wrapping; first set bit wins.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_cand = w_start + IDX_W'(i);
         if (!w_found && r_pending[w_cand]) begin
            w_sel   = w_cand;
            w_found = 1'b1;
         end
      end
   end

   assign w_load         = w_slot_free && w_found;
   assign w_load_mask    = w_load ? (WIDTH'(1) << w_sel) : '0;
   // A new event on the bit being loaded re-arms it instead of overflowing.
   assign w_pending_next = (r_pending & ~w_load_mask) | evt_in;
   assign w_drop         = |(evt_in & r_pending & ~w_load_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_ovf     <= 1'b0;
         r_ptr     <= '0;
      end else if (clr) begin
         r_pending <= '0;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_ovf     <= 1'b0;
         r_ptr     <= '0;
      end else begin
         r_pending <= w_pending_next;
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (w_slot_free) begin
            r_valid <= w_load;
            if (w_load) begin
               r_idx <= w_sel;
               if (RR) begin
                  r_ptr <= w_sel + IDX_W'(1);
               end
            end
         end
      end
   end

   assign idx_out   = r_idx;
   assign idx_valid = r_valid;
   assign pending   = r_pending;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_event_index_encoder.sv
// Bench for event_index_encoder: one fixed-priority and one round-robin instance,
// index stream checked against a queue of expected indices.
module tb_event_index_encoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] evt0, evt1;
   logic       clr0, clr1;
   logic       rdy0, rdy1;
   logic [2:0] idx0, idx1;
   logic       val0, val1;
   logic [7:0] pend0, pend1;
   logic       ovf0, ovf1;

   int checks = 0;
   int errors = 0;
   int hs0 = 0;
   logic [2:0] q0[$];
   logic [2:0] q1[$];

   typedef struct {
      logic [7:0] evt;
      int         n_idx;
   } vec_t;

   event_index_encoder #(.WIDTH(8), .IDX_W(3), .RR(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .evt_in(evt0), .clr(clr0),
      .idx_out(idx0), .idx_valid(val0), .idx_ready(rdy0),
      .pending(pend0), .ovf(ovf0)
   );

   event_index_encoder #(.WIDTH(8), .IDX_W(3), .RR(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .evt_in(evt1), .clr(clr1),
      .idx_out(idx1), .idx_valid(val1), .idx_ready(rdy1),
      .pending(pend1), .ovf(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required finish before 200000");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Inputs for the coming edge are already set; score any handshake, advance one cycle.
   task automatic tick();
      logic [2:0] e;
      if (val0 === 1'b1 && rdy0 === 1'b1) begin
         hs0++;
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL hs0: got idx %0d required no handshake", idx0);
         end else begin
            e = q0.pop_front();
            if (idx0 !== e) begin
               errors++;
               $display("FAIL hs0: got idx %0d required %0d", idx0, e);
            end
         end
      end
      if (val1 === 1'b1 && rdy1 === 1'b1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL hs1: got idx %0d required no handshake", idx1);
         end else begin
            e = q1.pop_front();
            if (idx1 !== e) begin
               errors++;
               $display("FAIL hs1: got idx %0d required %0d", idx1, e);
            end
         end
      end
      @(negedge clk);
      evt0 = '0;
      evt1 = '0;
      clr0 = 1'b0;
      clr1 = 1'b0;
   endtask

   task automatic drain(input int sel, output int n);
      n = 0;
      while (n < 40 && ((sel == 0) ? (val0 === 1'b1 || q0.size() != 0)
                                   : (val1 === 1'b1 || q1.size() != 0))) begin
         tick();
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL drain%0d: got stream still busy after %0d cycles required empty", sel, n);
      end
   endtask

   vec_t vecs[6];
   int   n;
   int   h_start;

   initial begin
      vecs[0] = '{evt: 8'h20, n_idx: 1};
      vecs[1] = '{evt: 8'h81, n_idx: 2};
      vecs[2] = '{evt: 8'h5A, n_idx: 4};
      vecs[3] = '{evt: 8'hFF, n_idx: 8};
      vecs[4] = '{evt: 8'h01, n_idx: 1};
      vecs[5] = '{evt: 8'h80, n_idx: 1};

      rst_n = 1'b0;
      evt0 = '0; evt1 = '0; clr0 = 1'b0; clr1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_pend0", 32'(pend0), 32'h0);
      chk("rst_val0", 32'(val0), 32'h0);
      chk("rst_idx0", 32'(idx0), 32'h0);
      chk("rst_ovf0", 32'(ovf0), 32'h0);
      chk("rst_val1", 32'(val1), 32'h0);
      rst_n = 1'b1;

      // Single event latency: pending after t, valid for exactly one cycle after t+1.
      rdy0 = 1'b1;
      evt0 = 8'h20;
      q0.push_back(3'd5);
      tick();
      chk("single_pend_t", 32'(pend0), 32'h20);
      chk("single_val_t", 32'(val0), 32'h0);
      tick();
      chk("single_val_t1", 32'(val0), 32'h1);
      chk("single_idx_t1", 32'(idx0), 32'h5);
      chk("single_pend_t1", 32'(pend0), 32'h0);
      tick();
      chk("single_val_t2", 32'(val0), 32'h0);

      // Fixed-priority table: ascending order, one index per cycle.
      for (int v = 0; v < 6; v++) begin
         evt0 = vecs[v].evt;
         for (int b = 0; b < 8; b++) begin
            if (vecs[v].evt[b]) q0.push_back(3'(b));
         end
         h_start = hs0;
         tick();
         drain(0, n);
         chk($sformatf("fp_hs_%0d", v), 32'(hs0 - h_start), 32'(vecs[v].n_idx));
         chk($sformatf("fp_cyc_%0d", v), 32'(n), 32'(vecs[v].n_idx + 1));
         chk($sformatf("fp_pend_%0d", v), 32'(pend0), 32'h0);
         chk($sformatf("fp_ovf_%0d", v), 32'(ovf0), 32'h0);
      end

      // Round-robin sequence.
      rdy1 = 1'b1;
      evt1 = 8'h08;
      q1.push_back(3'd3);
      tick();
      drain(1, n);
      evt1 = 8'h11;
      q1.push_back(3'd4); q1.push_back(3'd0);
      tick();
      drain(1, n);
      evt1 = 8'hFF;
      for (int b = 1; b < 9; b++) q1.push_back(3'(b % 8));
      tick();
      drain(1, n);
      chk("rr_ff_cycles", 32'(n), 32'd9);
      chk("rr_ovf", 32'(ovf1), 32'h0);

      // Backpressure and overflow.
      rdy0 = 1'b0;
      evt0 = 8'h06;
      q0.push_back(3'd1); q0.push_back(3'd2);
      tick();
      tick();
      chk("bp_idx", 32'(idx0), 32'h1);
      chk("bp_val", 32'(val0), 32'h1);
      chk("bp_pend", 32'(pend0), 32'h04);
      tick();
      chk("bp_idx_stable", 32'(idx0), 32'h1);
      evt0 = 8'h04;
      tick();
      chk("bp_ovf", 32'(ovf0), 32'h1);
      chk("bp_pend_kept", 32'(pend0), 32'h04);
      chk("bp_idx_kept", 32'(idx0), 32'h1);
      rdy0 = 1'b1;
      tick();
      chk("bp_idx2", 32'(idx0), 32'h2);
      tick();
      chk("bp_val_end", 32'(val0), 32'h0);
      chk("bp_ovf_sticky", 32'(ovf0), 32'h1);
      clr0 = 1'b1;
      tick();
      chk("bp_ovf_clr", 32'(ovf0), 32'h0);

      // Re-arm a bit that is currently presented.
      rdy0 = 1'b0;
      evt0 = 8'h08;
      q0.push_back(3'd3); q0.push_back(3'd3);
      tick();
      tick();
      chk("rearm_idx", 32'(idx0), 32'h3);
      evt0 = 8'h08;
      tick();
      chk("rearm_pend", 32'(pend0), 32'h08);
      chk("rearm_ovf", 32'(ovf0), 32'h0);
      rdy0 = 1'b1;
      tick();
      chk("rearm_idx_again", 32'(idx0), 32'h3);
      chk("rearm_pend0", 32'(pend0), 32'h0);
      drain(0, n);

      // Same-cycle load and event on bit 3.
      evt0 = 8'h08;
      q0.push_back(3'd3);
      tick();
      evt0 = 8'h08;
      q0.push_back(3'd3);
      tick();
      chk("same_pend", 32'(pend0), 32'h08);
      chk("same_ovf", 32'(ovf0), 32'h0);
      chk("same_val", 32'(val0), 32'h1);
      drain(0, n);
      chk("same_ovf_end", 32'(ovf0), 32'h0);

      // Synchronous clear while loaded and pending.
      rdy0 = 1'b0;
      evt0 = 8'h02;
      tick();
      evt0 = 8'hF0;
      tick();
      chk("clr_pre_pend", 32'(pend0), 32'hF0);
      chk("clr_pre_idx", 32'(idx0), 32'h1);
      clr0 = 1'b1;
      evt0 = 8'h01;
      tick();
      chk("clr_pend", 32'(pend0), 32'h0);
      chk("clr_val", 32'(val0), 32'h0);
      chk("clr_idx", 32'(idx0), 32'h0);
      chk("clr_ovf", 32'(ovf0), 32'h0);
      rdy0 = 1'b1;
      tick();
      tick();
      chk("clr_quiet", 32'(val0), 32'h0);

      // Asynchronous reset mid-cycle.
      rdy0 = 1'b0;
      evt0 = 8'h02;
      tick();
      evt0 = 8'hF0;
      tick();
      chk("rst_pre_idx", 32'(idx0), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pend", 32'(pend0), 32'h0);
      chk("arst_val", 32'(val0), 32'h0);
      chk("arst_idx", 32'(idx0), 32'h0);
      chk("arst_ovf", 32'(ovf0), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rdy0 = 1'b1;
      tick();
      chk("arst_quiet", 32'(val0), 32'h0);

      // Round-robin pointer restarts at 0 after reset.
      evt1 = 8'h81;
      q1.push_back(3'd0); q1.push_back(3'd7);
      tick();
      drain(1, n);

      chk("q0_empty", 32'(q0.size()), 32'h0);
      chk("q1_empty", 32'(q1.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
